// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: on a fetch request, reads one word over a two-phase
// (address, then data) valid/ready bus and presents it to the decoder.
module inst_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_fetch,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  output logic [ADDR_WIDTH-1:0] ir_addr,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic [INST_WIDTH-1:0] ir_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  busy,
  output logic                  fetch_misaligned,
  output logic                  fetch_overrun
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      addr_q           <= '0;
      inst             <= '0;
      inst_valid       <= 1'b0;
      fetch_misaligned <= 1'b0;
      fetch_overrun    <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      // A request while a transaction is in flight is dropped, only flagged.
      if (inst_fetch && state != IDLE) fetch_overrun <= 1'b1;
      case (state)
        IDLE: if (inst_fetch) begin
          addr_q <= {pc[ADDR_WIDTH-1:2], 2'b00};
          if (pc[1:0] != 2'b00) fetch_misaligned <= 1'b1;
          state <= ADDR;
        end
        ADDR: if (ir_addr_ready) state <= DATA;
        DATA: if (ir_data_valid) begin
          inst       <= ir_data;
          inst_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus handshake outputs decode the state register only, never an input.
  assign ir_addr_valid = (state == ADDR);
  assign ir_data_ready = (state == DATA);
  assign busy          = (state != IDLE);
  assign ir_addr       = addr_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus queues expected addresses and
// instructions (with arrival cycle); a negedge monitor checks what the DUT presents.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_fetch = 1'b0;
  logic [31:0] pc = '0;
  logic        ir_addr_valid;
  logic        ir_addr_ready = 1'b0;
  logic [31:0] ir_addr;
  logic        ir_data_valid = 1'b0;
  logic        ir_data_ready;
  logic [31:0] ir_data = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        busy;
  logic        fetch_misaligned;
  logic        fetch_overrun;

  inst_fetch_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .inst_fetch(inst_fetch), .pc(pc),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .inst(inst), .inst_valid(inst_valid), .busy(busy),
    .fetch_misaligned(fetch_misaligned), .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  logic [31:0] addr_exp[$];
  exp_t        inst_exp[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_inst = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: address channel contents and instruction pulses vs scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      addr_exp.delete();
      inst_exp.delete();
    end else begin
      if (ir_addr_valid) begin
        if (addr_exp.size() == 0) chk("spurious_addr_valid", 32'(ir_addr_valid), 32'd0);
        else begin
          chk("ir_addr", ir_addr, addr_exp[0]);
          if (ir_addr_ready) void'(addr_exp.pop_front());
        end
      end
      if (inst_valid) begin
        if (inst_exp.size() == 0) chk("spurious_inst_valid", 32'(inst_valid), 32'd0);
        else begin
          exp_t e;
          e = inst_exp.pop_front();
          chk("inst_at_pulse", inst, e.word);
          chk("inst_valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // One complete fetch starting in the current cycle (cycle 0).
  task automatic do_fetch(input logic [31:0] p, input logic [31:0] d,
                          input int aw, input int dw, input bit early);
    int c0;
    c0 = cyc;
    addr_exp.push_back({p[31:2], 2'b00});
    inst_exp.push_back('{d, c0 + 3 + aw + dw});
    inst_fetch = 1'b1; pc = p;
    tick();
    inst_fetch = 1'b0;
    chk("busy_c1", 32'(busy), 32'd1);
    chk("data_ready_in_addr", 32'(ir_data_ready), 32'd0);
    if (early) begin ir_data_valid = 1'b1; ir_data = d; end
    else ir_data = 32'hBAD0BAD0;
    repeat (aw) tick();
    ir_addr_ready = 1'b1;
    tick();
    ir_addr_ready = 1'b0;
    chk("data_ready", 32'(ir_data_ready), 32'd1);
    chk("addr_valid_in_data", 32'(ir_addr_valid), 32'd0);
    chk("inst_hold", inst, last_inst);
    repeat (dw) tick();
    ir_data = d; ir_data_valid = 1'b1;
    tick();
    ir_data_valid = 1'b0;
    chk("busy_done", 32'(busy), 32'd0);
    chk("inst_q", inst, d);
    last_inst = d;
  endtask

  initial begin
    int c0;
    tick(); tick();
    chk("rst_addr_valid", 32'(ir_addr_valid), 32'd0);
    chk("rst_data_ready", 32'(ir_data_ready), 32'd0);
    chk("rst_ir_addr", ir_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {30'd0, fetch_misaligned, fetch_overrun}, 32'd0);
    rst = 1'b1;
    tick();

    do_fetch(32'h100, 32'h00500093, 0, 0, 1'b0);     // zero wait
    tick();
    do_fetch(32'h104, 32'h12345678, 2, 3, 1'b0);     // inst_valid on cycle 8
    tick(); tick();
    do_fetch(32'h108, 32'hDEADBEEF, 2, 0, 1'b1);     // data valid held from ADDR
    tick();

    // Overrun: second request on cycle 2 is dropped.
    chk("overrun_before", 32'(fetch_overrun), 32'd0);
    c0 = cyc;
    addr_exp.push_back(32'h100);
    inst_exp.push_back('{32'h00A00113, c0 + 3});
    inst_fetch = 1'b1; pc = 32'h100;
    tick();
    inst_fetch = 1'b0; ir_addr_ready = 1'b1;
    tick();
    ir_addr_ready = 1'b0;
    inst_fetch = 1'b1; pc = 32'h200;
    ir_data = 32'h00A00113; ir_data_valid = 1'b1;
    tick();
    inst_fetch = 1'b0; ir_data_valid = 1'b0;
    chk("overrun_set", 32'(fetch_overrun), 32'd1);
    chk("overrun_inst", inst, 32'h00A00113);
    last_inst = 32'h00A00113;
    tick(); tick(); tick();

    // Misaligned then aligned back-to-back (fetch in the inst_valid cycle).
    chk("misaligned_before", 32'(fetch_misaligned), 32'd0);
    do_fetch(32'h102, 32'h0FF00193, 0, 0, 1'b0);
    chk("misaligned_set", 32'(fetch_misaligned), 32'd1);
    do_fetch(32'h200, 32'h00000013, 1, 1, 1'b0);
    chk("misaligned_sticky", 32'(fetch_misaligned), 32'd1);
    chk("overrun_sticky", 32'(fetch_overrun), 32'd1);
    tick();

    // Reset during ADDR on cycle 2.
    addr_exp.push_back(32'h300);
    inst_fetch = 1'b1; pc = 32'h300;
    tick();
    inst_fetch = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstmid_addr_valid", 32'(ir_addr_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_inst", inst, 32'd0);
    chk("rstmid_ir_addr", ir_addr, 32'd0);
    chk("rstmid_flags", {30'd0, fetch_misaligned, fetch_overrun}, 32'd0);
    last_inst = '0;
    tick();
    do_fetch(32'h400, 32'hCAFEF00D, 0, 0, 1'b0);
    tick(); tick(); tick();

    chk("addr_queue_empty", 32'(addr_exp.size()), 32'd0);
    chk("inst_queue_empty", 32'(inst_exp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
